// File: rtl/alarm_pkg.sv
// Shared state codes, event codes, field codes and BCD time type for the
// alarm-clock button controller and its BCD adder.
package alarm_pkg;

  localparam logic [2:0] ST_RUN      = 3'd0;
  localparam logic [2:0] ST_EDIT_H   = 3'd1;
  localparam logic [2:0] ST_EDIT_M   = 3'd2;
  localparam logic [2:0] ST_LOAD     = 3'd3;
  localparam logic [2:0] ST_STOP     = 3'd4;
  localparam logic [2:0] ST_SNZ_STOP = 3'd5;

  localparam logic [2:0] EV_NONE = 3'd0;
  localparam logic [2:0] EV_MODE = 3'd1;
  localparam logic [2:0] EV_ASET = 3'd2;
  localparam logic [2:0] EV_OK   = 3'd3;
  localparam logic [2:0] EV_INC  = 3'd4;
  localparam logic [2:0] EV_ALEN = 3'd5;

  localparam logic [1:0] FIELD_NONE    = 2'b00;
  localparam logic [1:0] FIELD_HOURS   = 2'b01;
  localparam logic [1:0] FIELD_MINUTES = 2'b10;

  localparam int HOUR_MAX = 23;
  localparam int MIN_MAX  = 59;

  typedef struct packed {
    logic [1:0] h1;
    logic [3:0] h0;
    logic [3:0] m1;
    logic [3:0] m0;
  } bcd_time_t;

endpackage

// File: rtl/bcd_time_add.sv
// Combinational BCD hh:mm adder: either +1 hour, or +min_inc minutes with
// carry into hours; both wrap at 23:59.
module bcd_time_add
  import alarm_pkg::*;
(
  input  bcd_time_t  t,
  input  logic [3:0] min_inc,
  input  logic       hour_only,
  output bcd_time_t  sum
);

  logic [7:0] min_sum;
  logic [7:0] hour_sum;
  logic       carry;

  always_comb begin
    // NOTE: blocking assignments here -- each line uses the value just computed above it.
    min_sum  = 8'(t.m1) * 8'd10 + 8'(t.m0);
    hour_sum = 8'(t.h1) * 8'd10 + 8'(t.h0);
    carry    = 1'b0;
    if (!hour_only) begin
      min_sum = min_sum + 8'(min_inc);
      if (min_sum > 8'(MIN_MAX)) begin
        min_sum = min_sum - 8'(MIN_MAX + 1);
        carry   = 1'b1;
      end
    end
    hour_sum = hour_sum + (hour_only ? 8'd1 : {7'd0, carry});
    if (hour_sum > 8'(HOUR_MAX)) hour_sum = hour_sum - 8'(HOUR_MAX + 1);
    sum.h1 = 2'(hour_sum / 8'd10);
    sum.h0 = 4'(hour_sum % 8'd10);
    sum.m1 = 4'(min_sum / 8'd10);
    sum.m0 = 4'(min_sum % 8'd10);
  end

endmodule

// File: rtl/alarm_set_ctrl.sv
// Button front-end for the Aclock core: edit sessions for time/alarm, timed
// load strobes, alarm enable, stop and snooze.
module alarm_set_ctrl
  import alarm_pkg::*;
#(
  parameter int LD_CYCLES    = 4,
  parameter int STOP_CYCLES  = 4,
  parameter int SNOOZE_MIN   = 5,
  parameter int EDIT_TIMEOUT = 600
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_mode,
  input  logic       btn_aset,
  input  logic       btn_inc,
  input  logic       btn_ok,
  input  logic       btn_alen,
  input  logic [1:0] cur_H1,
  input  logic [3:0] cur_H0,
  input  logic [3:0] cur_M1,
  input  logic [3:0] cur_M0,
  input  logic       alarm_in,
  output logic [1:0] H_in1,
  output logic [3:0] H_in0,
  output logic [3:0] M_in1,
  output logic [3:0] M_in0,
  output logic       LD_time,
  output logic       LD_alarm,
  output logic       STOP_al,
  output logic       AL_ON,
  output logic [1:0] edit_field,
  output logic       edit_alarm
);

  localparam int IDLE_W = $clog2(EDIT_TIMEOUT + 1);
  localparam logic [IDLE_W-1:0] IDLE_LIMIT = IDLE_W'(EDIT_TIMEOUT);
  localparam logic [3:0] LD_LAST   = 4'(LD_CYCLES - 1);
  localparam logic [3:0] STOP_LAST = 4'(STOP_CYCLES - 1);

  logic [2:0]        state;
  logic [4:0]        btn_now, btn_prev, press;
  logic [2:0]        ev;
  logic [3:0]        phase;
  logic [IDLE_W-1:0] idle_cnt;
  bcd_time_t         cur_t, edit_t, shadow_t, inc_t, snz_t;

  assign btn_now = {btn_mode, btn_aset, btn_ok, btn_inc, btn_alen};
  assign press   = btn_now & ~btn_prev;
  assign cur_t   = {cur_H1, cur_H0, cur_M1, cur_M0};

  always_comb begin
    // NOTE: default first, so every path assigns ev and no latch is inferred.
    ev = EV_NONE;
    if      (press[4]) ev = EV_MODE;
    else if (press[3]) ev = EV_ASET;
    else if (press[2]) ev = EV_OK;
    else if (press[1]) ev = EV_INC;
    else if (press[0]) ev = EV_ALEN;
  end

  bcd_time_add u_edit_add (
    .t(edit_t), .min_inc(4'd1), .hour_only(state == ST_EDIT_H), .sum(inc_t)
  );

  bcd_time_add u_snooze_add (
    .t(cur_t), .min_inc(4'(SNOOZE_MIN)), .hour_only(1'b0), .sum(snz_t)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_RUN;
      btn_prev   <= '0;
      phase      <= '0;
      idle_cnt   <= '0;
      edit_t     <= '0;
      shadow_t   <= '0;
      AL_ON      <= 1'b0;
      edit_alarm <= 1'b0;
    end else begin
      // NOTE: non-blocking throughout, so every branch sees pre-edge state.
      btn_prev <= btn_now;
      case (state)
        ST_RUN: begin
          phase    <= '0;
          idle_cnt <= '0;
          case (ev)
            EV_MODE: begin
              edit_t <= cur_t; edit_alarm <= 1'b0; state <= ST_EDIT_H;
            end
            EV_ASET: begin
              edit_t <= shadow_t; edit_alarm <= 1'b1; state <= ST_EDIT_H;
            end
            EV_OK:   if (alarm_in) state <= ST_STOP;
            EV_INC:  if (alarm_in && AL_ON) begin
              edit_t <= snz_t; edit_alarm <= 1'b1; state <= ST_SNZ_STOP;
            end
            EV_ALEN: AL_ON <= ~AL_ON;
            default: ;
          endcase
        end
        ST_EDIT_H, ST_EDIT_M: begin
          if (idle_cnt == IDLE_LIMIT) begin
            state <= ST_RUN; edit_alarm <= 1'b0;
          end else begin
            idle_cnt <= (|press) ? '0 : idle_cnt + 1'b1;
            case (ev)
              EV_MODE: begin state <= ST_RUN; edit_alarm <= 1'b0; end
              EV_OK:   state <= (state == ST_EDIT_H) ? ST_EDIT_M : ST_LOAD;
              EV_INC:  if (state == ST_EDIT_H) edit_t <= inc_t;
                       else begin edit_t.m1 <= inc_t.m1; edit_t.m0 <= inc_t.m0; end
              default: ;
            endcase
          end
        end
        ST_LOAD: begin
          if (phase == '0 && edit_alarm) shadow_t <= edit_t;
          if (phase == LD_LAST) begin
            phase <= '0; state <= ST_RUN; edit_alarm <= 1'b0;
          end else phase <= phase + 1'b1;
        end
        ST_STOP, ST_SNZ_STOP: begin
          if (phase == STOP_LAST) begin
            phase <= '0;
            state <= (state == ST_STOP) ? ST_RUN : ST_LOAD;
          end else phase <= phase + 1'b1;
        end
        default: state <= ST_RUN;
      endcase
    end
  end

  // Outputs are decoded from the registered state, so they trail it by one cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      {H_in1, H_in0, M_in1, M_in0} <= '0;
      LD_time    <= 1'b0;
      LD_alarm   <= 1'b0;
      STOP_al    <= 1'b0;
      edit_field <= FIELD_NONE;
    end else begin
      LD_time  <= (state == ST_LOAD) && !edit_alarm;
      LD_alarm <= (state == ST_LOAD) && edit_alarm;
      STOP_al  <= (state == ST_STOP) || (state == ST_SNZ_STOP);
      case (state)
        ST_EDIT_H: edit_field <= FIELD_HOURS;
        ST_EDIT_M: edit_field <= FIELD_MINUTES;
        default:   edit_field <= FIELD_NONE;
      endcase
      if (state == ST_LOAD) {H_in1, H_in0, M_in1, M_in0} <= edit_t;
    end
  end

endmodule
